filt_seq: RTL

Filter sequencer for one SDFM data-filter channel. Runs in the sigma-delta clock domain, generates the decimation strobe, and clears the integrator/comb registers on enable, restart and configuration change. Suppresses the first unsettled sinc outputs and publishes a qualified data-valid pulse and sample count. Sits between the register block and the integrator/comb datapath, replacing a free-running decimation counter.

---
 rtl/sdfm_filt_pkg.sv | 28 ++
 rtl/filt_dec_cnt.sv | 33 +++
 rtl/filt_seq.sv | 108 ++++++++++
 3 files changed

// File: rtl/sdfm_filt_pkg.sv
// Shared definitions for the SDFM data-filter sequencer: state encoding,
// filter-structure codes and the per-structure discard count.
package sdfm_filt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_CLEAR  = 2'b01,
        ST_SETTLE = 2'b10,
        ST_RUN    = 2'b11
    } filt_state_e;

    localparam logic [1:0] SINCFAST = 2'b00;
    localparam logic [1:0] SINC1    = 2'b01;
    localparam logic [1:0] SINC2    = 2'b10;
    localparam logic [1:0] SINC3    = 2'b11;

    // Number of unsettled sinc outputs to throw away after a clear.
    function automatic logic [1:0] discard_n(input logic [1:0] filtst);
        logic [1:0] n;
        case (filtst)
            SINC1:   n = 2'd1;
            SINC2:   n = 2'd2;
            default: n = 2'd3;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/filt_dec_cnt.sv
// 8-bit decimation counter; strobe marks the last cycle of each period.
module filt_dec_cnt (
    input  logic       sd_clk_in,
    input  logic       SYSRSTn,
    input  logic       clr,
    input  logic       run,
    input  logic [7:0] period,
    output logic       strobe
);

    logic [7:0] dcnt_q;
    logic [7:0] dcnt_d;

    always_comb begin
        dcnt_d = dcnt_q;
        if (clr) begin
            dcnt_d = '0;
        end else if (run) begin
            dcnt_d = (dcnt_q == period) ? 8'd0 : dcnt_q + 8'd1;
        end
    end

    always_ff @(posedge sd_clk_in or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            dcnt_q <= '0;
        end else begin
            dcnt_q <= dcnt_d;
        end
    end

    assign strobe = run && (dcnt_q == period);

endmodule

// File: rtl/filt_seq.sv
// Filter sequencer for one SDFM data-filter channel: decimation strobe,
// integrator/comb clears, settle suppression and valid-sample counting.
module filt_seq
    import sdfm_filt_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             sd_clk_in,
    input  logic             SYSRSTn,
    input  logic             reg_filten,
    input  logic [7:0]       reg_filtdec,
    input  logic [1:0]       reg_filtst,
    input  logic             sync_en,
    input  logic             sync_req,
    output logic             dec_strobe,
    output logic             integ_clr,
    output logic             comb_clr,
    output logic             data_valid,
    output logic             settling,
    output logic [1:0]       seq_state,
    output logic [CNT_W-1:0] sample_cnt
);

    filt_state_e      state_q, state_d;
    logic [7:0]       sh_dec_q, sh_dec_d;
    logic [1:0]       sh_st_q, sh_st_d;
    logic [1:0]       scnt_q, scnt_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;

    logic in_clr;
    logic active;
    logic cfg_chg;
    logic settle_done;

    assign in_clr  = (state_q == ST_IDLE) || (state_q == ST_CLEAR);
    assign active  = (state_q == ST_SETTLE) || (state_q == ST_RUN);
    assign cfg_chg = (reg_filtdec != sh_dec_q) || (reg_filtst != sh_st_q);

    filt_dec_cnt u_dec_cnt (
        .sd_clk_in (sd_clk_in),
        .SYSRSTn   (SYSRSTn),
        .clr       (in_clr),
        .run       (active),
        .period    (sh_dec_q),
        .strobe    (dec_strobe)
    );

    assign settle_done = dec_strobe && (scnt_q == discard_n(sh_st_q) - 2'd1);

    always_comb begin
        state_d = state_q;
        if (!reg_filten) begin
            state_d = ST_IDLE;
        end else if (active && (cfg_chg || (sync_en && sync_req))) begin
            state_d = ST_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE:   state_d = ST_CLEAR;
                ST_CLEAR:  state_d = ST_SETTLE;
                ST_SETTLE: if (settle_done) state_d = ST_RUN;
                default:   state_d = state_q;
            endcase
        end
    end

    always_comb begin
        sh_dec_d     = sh_dec_q;
        sh_st_d      = sh_st_q;
        scnt_d       = scnt_q;
        sample_cnt_d = sample_cnt_q;
        if (in_clr) begin
            sh_dec_d = reg_filtdec;
            sh_st_d  = reg_filtst;
        end
        if (state_q == ST_CLEAR) begin
            scnt_d       = '0;
            sample_cnt_d = '0;
        end else begin
            if ((state_q == ST_SETTLE) && dec_strobe) scnt_d = scnt_q + 2'd1;
            if (data_valid) sample_cnt_d = sample_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge sd_clk_in or negedge SYSRSTn) begin
        if (!SYSRSTn) begin
            state_q      <= ST_IDLE;
            sh_dec_q     <= '0;
            sh_st_q      <= '0;
            scnt_q       <= '0;
            sample_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            sh_dec_q     <= sh_dec_d;
            sh_st_q      <= sh_st_d;
            scnt_q       <= scnt_d;
            sample_cnt_q <= sample_cnt_d;
        end
    end

    // data_valid is gated by the live enable so it drops in the same cycle.
    assign data_valid = dec_strobe && (state_q == ST_RUN) && reg_filten;
    assign integ_clr  = in_clr;
    assign comb_clr   = in_clr;
    assign settling   = (state_q == ST_SETTLE);
    assign seq_state  = state_q;
    assign sample_cnt = sample_cnt_q;

endmodule
